// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_DIV_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..i_cfg_div and wraps, restarting on i_restart.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DivWidth = UART_DIV_W
) (
  input  logic                main_clk_i,
  input  logic                main_rst_an_i,
  input  logic                i_restart,
  input  logic                i_enable,
  input  logic [DivWidth-1:0] i_cfg_div,
  output logic                o_bit_last
);

  logic [DivWidth-1:0] r_cnt;

  assign o_bit_last = (r_cnt == i_cfg_div);

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (o_bit_last) r_cnt <= '0;
      else            r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 8 data bits LSB-first, optional parity, 1 or 2 stops.
// Handshake: a byte is accepted on any cycle where tx_valid_i && tx_ready_o; tx_valid_i may drop freely while tx_ready_o is low.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DataWidth = UART_DATA_W,
  parameter int DivWidth  = UART_DIV_W
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_an_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DivWidth-1:0]  cfg_div_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic                 cfg_stop2_i,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic                 done_o,
  output uart_tx_state_e       dbg_state_o
);

  localparam int IdxW = $clog2(DataWidth);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DataWidth - 1);

  uart_tx_state_e      r_state;
  logic [DataWidth-1:0] r_shift;
  logic [IdxW-1:0]     r_bit_idx;
  logic                r_par;
  logic                r_par_en;
  logic                r_stop2;
  logic                r_stop_cnt;
  logic [DivWidth-1:0] r_div;
  logic                r_txd;

  logic w_bit_last;
  logic w_stop_last;
  logic w_accept;
  logic w_par_next;

  uart_baud_gen #(
    .DivWidth(DivWidth)
  ) u_baud (
    .main_clk_i   (main_clk_i),
    .main_rst_an_i(main_rst_an_i),
    .i_restart    (w_accept),
    .i_enable     (r_state != IDLE),
    .i_cfg_div    (r_div),
    .o_bit_last   (w_bit_last)
  );

  // Final cycle of the last stop bit: frame ends and the next byte may be taken.
  assign w_stop_last = (r_state == STOP) && w_bit_last && (!r_stop2 || r_stop_cnt);
  assign tx_ready_o  = (r_state == IDLE) || w_stop_last;
  assign w_accept    = tx_valid_i && tx_ready_o;
  assign w_par_next  = r_par ^ r_shift[0];

  assign txd_o       = r_txd;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = w_stop_last;
  assign dbg_state_o = r_state;

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_div      <= '0;
      r_txd      <= 1'b1;
    end else if (w_accept) begin
      r_state    <= START;
      r_txd      <= 1'b0;
      r_shift    <= tx_data_i;
      r_par      <= cfg_parity_odd_i;
      r_par_en   <= cfg_parity_en_i;
      r_stop2    <= cfg_stop2_i;
      r_div      <= cfg_div_i;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
    end else if (w_bit_last) begin
      unique case (r_state)
        START: begin
          r_state <= DATA;
          r_txd   <= r_shift[0];
        end
        DATA: begin
          r_par   <= w_par_next;
          r_shift <= {1'b0, r_shift[DataWidth-1:1]};
          if (r_bit_idx == LastIdx) begin
            r_bit_idx <= '0;
            if (r_par_en) begin
              r_state <= PARITY;
              r_txd   <= w_par_next;
            end else begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end
          end else begin
            r_bit_idx <= r_bit_idx + 1'b1;
            r_txd     <= r_shift[1];
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_txd   <= 1'b1;
        end
        STOP: begin
          if (w_stop_last) begin
            r_state <= IDLE;
            r_txd   <= 1'b1;
          end else begin
            r_stop_cnt <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl using a bit-list frame model.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     tx_data = 8'h00;
  logic           tx_valid = 1'b0;
  logic           tx_ready;
  logic [15:0]    cfg_div = 16'd0;
  logic           cfg_par_en = 1'b0;
  logic           cfg_par_odd = 1'b0;
  logic           cfg_stop2 = 1'b0;
  logic           txd;
  logic           busy;
  logic           done;
  uart_tx_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle vector {txd, busy, done, ready}
  logic [3:0] exp_q[$];
  logic [7:0] byte_q[$];

  uart_tx_ctrl dut (
    .main_clk_i      (clk),
    .main_rst_an_i   (rst_n),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .cfg_div_i       (cfg_div),
    .cfg_parity_en_i (cfg_par_en),
    .cfg_parity_odd_i(cfg_par_odd),
    .cfg_stop2_i     (cfg_stop2),
    .txd_o           (txd),
    .busy_o          (busy),
    .done_o          (done),
    .dbg_state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {txd, busy, done, tx_ready};
  endfunction

  task automatic drive_cfg(input int div, input bit pen, input bit podd, input bit st2);
    cfg_div     = div[15:0];
    cfg_par_en  = pen;
    cfg_par_odd = podd;
    cfg_stop2   = st2;
  endtask

  task automatic push_frame(input logic [7:0] d, input int div, input bit pen,
                            input bit podd, input bit st2);
    bit bits[$];
    int n;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ podd);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    n = bits.size() * (div + 1);
    for (int c = 0; c < n; c++) begin
      logic last;
      last = (c == n - 1);
      exp_q.push_back({bits[c / (div + 1)], 1'b1, last, last});
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (obs() !== 4'b1001) begin
      n_fail++;
      $display("FAIL %s: {txd,busy,done,ready} got %b expected 1001", name, obs());
    end
  endtask

  // Sends every byte in byte_q back to back with one configuration.
  task automatic run_frames(input string name, input int div, input bit pen,
                            input bit podd, input bit st2, input bit scramble);
    int idx;
    int cyc;
    logic [3:0] e;
    logic [3:0] got;
    exp_q.delete();
    foreach (byte_q[k]) push_frame(byte_q[k], div, pen, podd, st2);
    @(negedge clk);
    check_idle({name, "_pre"});
    drive_cfg(div, pen, podd, st2);
    tx_valid = 1'b1;
    tx_data  = byte_q[0];
    idx = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      e   = exp_q.pop_front();
      got = obs();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {txd,busy,done,ready} got %b expected %b", name, cyc, got, e);
      end
      if (e[1]) begin
        idx++;
        if (idx < byte_q.size()) begin
          drive_cfg(div, pen, podd, st2);
          tx_valid = 1'b1;
          tx_data  = byte_q[idx];
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
      end else if (scramble) begin
        drive_cfg($urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom));
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
      end
    end
    byte_q.delete();
    @(negedge clk);
    check_idle({name, "_post"});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset_release");
    end
  endtask

  task automatic test_basic();
    byte_q.push_back(8'hA5);
    run_frames("basic_a5", 3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    byte_q.push_back(8'h07);
    run_frames("parity_even", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    byte_q.push_back(8'h07);
    run_frames("parity_odd", 0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    byte_q.push_back(8'h00);
    byte_q.push_back(8'hFF);
    run_frames("back_to_back", 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stop2();
    byte_q.push_back(8'($urandom));
    run_frames("stop2", 1, 1'b1, 1'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_cfg_change();
    byte_q.push_back(8'($urandom));
    byte_q.push_back(8'($urandom));
    run_frames("cfg_change", 2, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h35;
    @(negedge clk);
    check_idle("midrst_pre");
    drive_cfg(3, 1'b0, 1'b0, 1'b0);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    n_tests++;
    if ({txd, busy} !== {d[3], 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_bit3: {txd,busy} got %b expected %b", {txd, busy}, {d[3], 1'b1});
    end
    rst_n = 1'b0;
    #1;
    check_idle("midrst_async");
    @(negedge clk);
    rst_n = 1'b1;
    byte_q.push_back(8'hC3);
    run_frames("midrst_after", 3, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int div;
    int nb;
    bit pen;
    bit podd;
    bit st2;
    for (int it = 0; it < 20; it++) begin
      div  = $urandom_range(0, 4);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      st2  = 1'($urandom);
      nb   = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) byte_q.push_back(8'($urandom));
      run_frames("random", div, pen, podd, st2, 1'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_idle("random_gap");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_stop2();
    test_cfg_change();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART core. It accepts bytes over a valid/ready handshake, generates bit timing from a programmable divider, and serializes each frame: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. busy_o feeds the core's busy indication.

Parameters:
DataWidth, 8, data bits per frame; fixed at 8 for this release.
DivWidth, 16, width of the baud divider configuration.

Ports:
main_clk_i  input  1  main clock
main_rst_an_i  input  1  async reset, low-active
tx_data_i  input  DataWidth  byte to transmit
tx_valid_i  input  1  tx_data_i valid
tx_ready_o  output  1  controller can accept a byte
cfg_div_i  input  DivWidth  bit period minus 1, in clock cycles
cfg_parity_en_i  input  1  append a parity bit
cfg_parity_odd_i  input  1  1 = odd parity, 0 = even parity
cfg_stop2_i  input  1  1 = two stop bits, 0 = one stop bit
txd_o  output  1  serial line, idle high
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock, main_clk_i. main_rst_an_i is asynchronous and active-low.
- Reset values: txd_o=1, busy_o=0, done_o=0, tx_ready_o=1, state IDLE, counters 0.
- Reset mid-frame: txd_o goes to 1 asynchronously and busy_o to 0. The frame is dropped and not replayed.
- States: IDLE, START, DATA, PARITY, STOP.
- Transitions: IDLE->START on accept; START->DATA; DATA->PARITY after bit 7 if parity is enabled, else DATA->STOP; PARITY->STOP; STOP->IDLE, or STOP->START if a byte is accepted in the final stop cycle.
- Accept: occurs on a cycle with tx_valid_i & tx_ready_o. On accept, tx_data_i and all cfg_* inputs are latched for the whole frame. cfg changes mid-frame have no effect until the next accept.
- tx_ready_o: high in IDLE and in the last cycle of the final stop bit, low otherwise. This gives gapless back-to-back frames.
- Output timing: txd_o is registered. The start bit drives txd_o=0 from the cycle after accept.
- Bit period: D = cfg_div+1 cycles. cfg_div=0 gives 1 cycle per bit, no special case. The divider counts 0..cfg_div and wraps. It restarts at 0 on every accept.
- Data: bits are sent LSB first. A 3-bit bit index wraps 7->0 at DATA exit.
- Parity: even = XOR of the 8 data bits; odd = inverted XOR.
- Frame length: (1 + 8 + P + S) * D cycles, where P = parity enable (0/1) and S = stop bits (1/2).
- busy_o: high from the cycle after accept through the last stop cycle. It stays high continuously across back-to-back frames.
- done_o: pulses in the last cycle of the final stop bit, coincident with tx_ready_o high.
- Protocol: tx_valid_i may drop while tx_ready_o=0 without effect. No data is buffered beyond the latched byte.

Decomposition:
- Package uart_pkg:
  - enum uart_tx_state_e (IDLE, START, DATA, PARITY, STOP)
  - localparam UART_DATA_W=8
  - localparam UART_DIV_W=16
- Sub-module uart_baud_gen:
  - divider counter with sync restart input and cfg_div input
  - outputs bit_last, high on the final cycle of each bit period
- The FSM, shift register and parity accumulation stay in uart_tx_ctrl.

Test Plan:
- Reset: hold main_rst_an_i=0 -> txd_o=1, busy_o=0, done_o=0, tx_ready_o=1. After release, values are unchanged while idle.
- Basic frame: div=3, no parity, 1 stop, send 0xA5 -> txd_o sequence 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles. Frame is 40 cycles; done_o pulses on cycle 40 after accept; busy_o is high for 40 cycles.
- Parity: div=0, parity even, send 0x07 -> parity bit 1; parity odd, send 0x07 -> parity bit 0. Each frame is 11 cycles.
- Back-to-back: div=0, 1 stop, tx_valid_i held high with 0x00 then 0xFF -> 20 cycles total with no idle gap. done_o pulses at cycles 10 and 20; busy_o stays high throughout.
- Two stop bits: div=1, stop2=1, parity on -> frame is 24 cycles. txd_o=1 for the last 4 cycles; tx_ready_o=1 only in the final cycle.
- Reset and cfg change: assert reset during data bit 3 -> txd_o=1 and busy_o=0 immediately; a new byte sent after release is correct. Separately, change cfg_div_i mid-frame -> frame timing is unchanged.
